mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch port, the data port, the unified memory and the arbiter.
// The arbiter takes the slave view; the core and memory side takes the master view.
interface mem_arbiter_if;
    // Fetch port
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    // Data port
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [2:0]  dm_ctr;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    // Unified memory
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_ctr;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    // Pipeline status
    logic        stall;
    logic        bus_err;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_ctr,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_ctr,
        input  mem_rdata, mem_ready,
        output stall, bus_err
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_ctr,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_ctr,
        output mem_rdata, mem_ready,
        input  stall, bus_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-outstanding unified memory.
// Data wins by default; after FAIR_MAX back-to-back data grants with a fetch waiting,
// the fetch is served. A memory access that sees no mem_ready for TIMEOUT cycles is
// aborted and reported through bus_err together with the owner's rvalid.
module mem_arbiter #(
    parameter int unsigned TIMEOUT  = 15,
    parameter int unsigned FAIR_MAX = 2
) (
    input  logic          i_clock,
    input  logic          i_reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StBusyIf, StBusyDm, StResp} state_e;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
    localparam logic [7:0] FairMax     = 8'(FAIR_MAX);

    state_e      r_state, w_state_d;
    logic [7:0]  r_fair_cnt, w_fair_cnt_d;
    logic [7:0]  r_wait_cnt, w_wait_cnt_d;
    logic        r_owner_dm;
    logic        r_err;
    logic        r_cmd_we;
    logic [31:0] r_cmd_addr;
    logic [31:0] r_cmd_wdata;
    logic [2:0]  r_cmd_ctr;
    logic [31:0] r_if_rdata;
    logic [31:0] r_dm_rdata;

    logic        w_grant_if;
    logic        w_grant_dm;
    logic        w_grant;
    logic        w_resp_load;
    logic        w_resp_err;
    logic        w_busy;
    logic        w_sel_we;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [2:0]  w_sel_ctr;
    logic [31:0] w_resp_data;

    assign w_grant = w_grant_if | w_grant_dm;
    assign w_busy  = (r_state == StBusyIf) || (r_state == StBusyDm);

    // Arbitration, fairness counter, wait counter and next state.
    always_comb begin
        w_state_d    = r_state;
        w_fair_cnt_d = r_fair_cnt;
        w_wait_cnt_d = r_wait_cnt;
        w_grant_if   = 1'b0;
        w_grant_dm   = 1'b0;
        w_resp_load  = 1'b0;
        w_resp_err   = 1'b0;
        case (r_state)
            StIdle: begin
                w_wait_cnt_d = 8'd0;
                // Requests seen while reset is high are never granted.
                if (!i_reset) begin
                    if (bus.if_req && (!bus.dm_req || (r_fair_cnt == FairMax))) begin
                        w_grant_if   = 1'b1;
                        w_state_d    = StBusyIf;
                        w_fair_cnt_d = 8'd0;
                    end else if (bus.dm_req) begin
                        w_grant_dm = 1'b1;
                        w_state_d  = StBusyDm;
                        if (!bus.if_req) begin
                            w_fair_cnt_d = 8'd0;
                        end else if (r_fair_cnt != FairMax) begin
                            w_fair_cnt_d = r_fair_cnt + 8'd1;
                        end
                    end
                end
            end
            StBusyIf, StBusyDm: begin
                w_wait_cnt_d = r_wait_cnt + 8'd1;
                if (bus.mem_ready) begin
                    w_state_d   = StResp;
                    w_resp_load = 1'b1;
                end else if (r_wait_cnt == TimeoutLast) begin
                    w_state_d   = StResp;
                    w_resp_load = 1'b1;
                    w_resp_err  = 1'b1;
                end
            end
            StResp: begin
                w_wait_cnt_d = 8'd0;
                w_state_d    = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Command selected by the winning port; fetches are always word reads.
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = bus.if_addr;
        w_sel_wdata = 32'd0;
        w_sel_ctr   = 3'b000;
        if (w_grant_dm) begin
            w_sel_we    = bus.dm_we;
            w_sel_addr  = bus.dm_addr;
            w_sel_wdata = bus.dm_wdata;
            w_sel_ctr   = bus.dm_ctr;
        end
    end

    // Aborted accesses return zero data.
    assign w_resp_data = w_resp_err ? 32'd0 : bus.mem_rdata;

    // State, counters, latched command and per-port read data.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_fair_cnt  <= 8'd0;
            r_wait_cnt  <= 8'd0;
            r_owner_dm  <= 1'b0;
            r_err       <= 1'b0;
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= 32'd0;
            r_cmd_wdata <= 32'd0;
            r_cmd_ctr   <= 3'b000;
            r_if_rdata  <= 32'd0;
            r_dm_rdata  <= 32'd0;
        end else begin
            r_state    <= w_state_d;
            r_fair_cnt <= w_fair_cnt_d;
            r_wait_cnt <= w_wait_cnt_d;
            if (w_grant) begin
                r_owner_dm  <= w_grant_dm;
                r_err       <= 1'b0;
                r_cmd_we    <= w_sel_we;
                r_cmd_addr  <= w_sel_addr;
                r_cmd_wdata <= w_sel_wdata;
                r_cmd_ctr   <= w_sel_ctr;
            end
            if (w_resp_load) begin
                r_err <= w_resp_err;
                if (r_owner_dm) begin
                    r_dm_rdata <= r_cmd_we ? 32'd0 : w_resp_data;
                end else begin
                    r_if_rdata <= w_resp_data;
                end
            end
        end
    end

    // Port outputs: the command is driven straight through on the mem_en cycle, then
    // from the latched copy so it stays stable until completion.
    always_comb begin
        bus.if_gnt    = w_grant_if;
        bus.dm_gnt    = w_grant_dm;
        bus.mem_en    = w_grant;
        bus.mem_we    = w_grant ? w_sel_we    : r_cmd_we;
        bus.mem_addr  = w_grant ? w_sel_addr  : r_cmd_addr;
        bus.mem_wdata = w_grant ? w_sel_wdata : r_cmd_wdata;
        bus.mem_ctr   = w_grant ? w_sel_ctr   : r_cmd_ctr;
        bus.if_rvalid = !i_reset && (r_state == StResp) && !r_owner_dm;
        bus.dm_rvalid = !i_reset && (r_state == StResp) && r_owner_dm;
        bus.bus_err   = !i_reset && (r_state == StResp) && r_err;
        bus.if_rdata  = r_if_rdata;
        bus.dm_rdata  = r_dm_rdata;
        bus.stall     = !i_reset && ((bus.if_req && !w_grant_if) ||
                                     (bus.dm_req && !w_grant_dm) || w_busy);
    end

endmodule
